// File: rtl/conv_sequencer.sv
// Sequences the 3x3 convolution engine over one image for a bank of kernels:
// weight fetch into the kernel bus, pixel streaming, then a bounded wait for the engine.
module conv_sequencer #(
    parameter  int NUM_KERNELS = 8,
    parameter  int K_WIDTH     = 12,
    parameter  int K_SIZE      = 9,
    parameter  int PIX_WIDTH   = 8,
    parameter  int IM_DIM      = 28,
    parameter  int TIMEOUT     = 1024,
    localparam int NPIX        = IM_DIM * IM_DIM,
    localparam int KIDX_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    localparam int WADDR_W     = $clog2(NUM_KERNELS * K_SIZE),
    localparam int PADDR_W     = $clog2(NPIX)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [KIDX_W-1:0]           kidx_o,
    output logic                        w_rd_o,
    output logic [WADDR_W-1:0]          w_addr_o,
    input  logic [K_WIDTH-1:0]          w_data_i,
    output logic                        img_rd_o,
    output logic [PADDR_W-1:0]          img_addr_o,
    input  logic [PIX_WIDTH-1:0]        img_data_i,
    output logic [K_SIZE*K_WIDTH-1:0]   k_val_o,
    output logic [PIX_WIDTH-1:0]        pixel_o,
    output logic                        pix_data_valid_o,
    input  logic                        conv_finished_i
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // S_IDLE   | waiting for start_i
    // S_LOAD_K | issuing K_SIZE weight reads for kernel r_kidx
    // S_STREAM | issuing NPIX image reads, one per cycle
    // S_DRAIN  | waiting for the engine's finish (or pending flag), bounded
    // S_NEXT   | one cycle: advance to the next kernel or finish the run
    // S_DONE   | one cycle: done_o pulse

    localparam int CNT_MAX0 = (K_SIZE > NPIX) ? K_SIZE : NPIX;
    localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int WSEL_W   = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [KIDX_W-1:0]            r_kidx;
    logic [WADDR_W-1:0]           r_w_addr;
    logic [PADDR_W-1:0]           r_img_addr;
    logic                         r_w_rd;
    logic                         r_img_rd;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;
    logic                         r_pend;

    logic                         r_w_rd_d;
    logic [WSEL_W-1:0]            r_wsel_d;
    logic [K_SIZE*K_WIDTH-1:0]    r_k_val;
    logic                         r_pix_vld;

    logic [WSEL_W-1:0]            w_wsel;

    // r_cnt counts down through LOAD_K, so the weight slot is its complement.
    assign w_wsel = WSEL_W'(K_SIZE - 1) - WSEL_W'(r_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_kidx     <= '0;
            r_w_addr   <= '0;
            r_img_addr <= '0;
            r_w_rd     <= 1'b0;
            r_img_rd   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_err    <= 1'b0;
                        r_kidx   <= '0;
                        r_w_addr <= '0;
                        r_cnt    <= CNT_W'(K_SIZE - 1);
                        r_w_rd   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_LOAD_K;
                    end
                end
                S_LOAD_K: begin
                    if (r_cnt == '0) begin
                        r_w_rd     <= 1'b0;
                        r_img_rd   <= 1'b1;
                        r_img_addr <= '0;
                        r_cnt      <= CNT_W'(NPIX - 1);
                        r_state    <= S_STREAM;
                    end else begin
                        r_cnt    <= r_cnt - CNT_W'(1);
                        r_w_addr <= r_w_addr + WADDR_W'(1);
                    end
                end
                S_STREAM: begin
                    if (conv_finished_i) begin
                        r_pend <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_img_rd <= 1'b0;
                        r_cnt    <= CNT_W'(TIMEOUT - 1);
                        r_state  <= S_DRAIN;
                    end else begin
                        r_cnt      <= r_cnt - CNT_W'(1);
                        r_img_addr <= r_img_addr + PADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // A finish on the last allowed cycle still wins over the timeout.
                    if (conv_finished_i || r_pend) begin
                        r_state <= S_NEXT;
                    end else if (r_cnt == '0) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    r_pend <= 1'b0;
                    if (r_kidx == KIDX_W'(NUM_KERNELS - 1)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_kidx   <= r_kidx + KIDX_W'(1);
                        r_w_addr <= r_w_addr + WADDR_W'(1);
                        r_cnt    <= CNT_W'(K_SIZE - 1);
                        r_w_rd   <= 1'b1;
                        r_state  <= S_LOAD_K;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the request, so the slot travels with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_w_rd_d  <= 1'b0;
            r_wsel_d  <= '0;
            r_k_val   <= '0;
            r_pix_vld <= 1'b0;
        end else begin
            r_w_rd_d  <= r_w_rd;
            r_wsel_d  <= w_wsel;
            r_pix_vld <= r_img_rd;
            if (r_w_rd_d) begin
                r_k_val[K_WIDTH*r_wsel_d +: K_WIDTH] <= w_data_i;
            end
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign kidx_o           = r_kidx;
    assign w_rd_o           = r_w_rd;
    assign w_addr_o         = r_w_addr;
    assign img_rd_o         = r_img_rd;
    assign img_addr_o       = r_img_addr;
    assign k_val_o          = r_k_val;
    assign pixel_o          = img_data_i;
    assign pix_data_valid_o = r_pix_vld;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a run-level timing model fills expectation
// queues at each start; a negedge monitor pops and compares every DUT event.
module tb_conv_sequencer;

    localparam int NK     = 3;
    localparam int KW     = 12;
    localparam int KS     = 9;
    localparam int PW     = 8;
    localparam int IMD    = 28;
    localparam int NPIX   = IMD * IMD;
    localparam int TO     = 16;
    localparam int KIDX_W = $clog2(NK);
    localparam int WA_W   = $clog2(NK * KS);
    localparam int PA_W   = $clog2(NPIX);
    localparam int NONE   = 1 << 20;

    typedef logic [127:0] v_t;
    typedef struct { int c; int addr; } wrd_t;
    typedef struct { int c; logic [PW-1:0] pix; logic [KS*KW-1:0] kv; int k; } pix_t;
    typedef struct { int c; bit err; } done_t;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  start_i = 1'b0;
    logic                  conv_finished_i = 1'b0;
    logic [KW-1:0]         w_data_i = '0;
    logic [PW-1:0]         img_data_i = '0;
    logic                  busy_o, done_o, err_o, w_rd_o, img_rd_o, pix_data_valid_o;
    logic [KIDX_W-1:0]     kidx_o;
    logic [WA_W-1:0]       w_addr_o;
    logic [PA_W-1:0]       img_addr_o;
    logic [KS*KW-1:0]      k_val_o;
    logic [PW-1:0]         pixel_o;

    conv_sequencer #(
        .NUM_KERNELS(NK), .K_WIDTH(KW), .K_SIZE(KS),
        .PIX_WIDTH(PW), .IM_DIM(IMD), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .kidx_o(kidx_o),
        .w_rd_o(w_rd_o), .w_addr_o(w_addr_o), .w_data_i(w_data_i),
        .img_rd_o(img_rd_o), .img_addr_o(img_addr_o), .img_data_i(img_data_i),
        .k_val_o(k_val_o), .pixel_o(pixel_o), .pix_data_valid_o(pix_data_valid_o),
        .conv_finished_i(conv_finished_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [KW-1:0] wmem [0:31];
    logic [PW-1:0] imem [0:1023];

    // Synchronous memories: data one cycle after the read, noise otherwise.
    always @(posedge clk_i) begin
        w_data_i   <= w_rd_o   ? wmem[w_addr_o]   : KW'($urandom);
        img_data_i <= img_rd_o ? imem[img_addr_o] : PW'($urandom);
    end

    bit fin_at [int];
    always @(negedge clk_i) conv_finished_i = rst_ni && fin_at.exists(cyc);

    wrd_t  q_wrd[$];
    pix_t  q_pix[$];
    done_t q_done[$];
    int    run_s = -1, run_done = -1;
    bit    run_err = 1'b0, prev_err = 1'b0;
    int    n_checks = 0, n_errors = 0;

    task automatic chk(input string nm, input v_t act, input v_t want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, want);
        end
    endtask

    bit    exp_busy, exp_err;
    wrd_t  ew;
    pix_t  ep;
    done_t ed;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            exp_busy = (cyc > run_s) && (cyc < run_done);
            exp_err  = (cyc <= run_s) ? prev_err : ((cyc >= run_done) ? run_err : 1'b0);
            chk("busy", v_t'(busy_o), v_t'(exp_busy));
            chk("err", v_t'(err_o), v_t'(exp_err));
            if (w_rd_o) begin
                if (q_wrd.size() == 0) chk("wrd_extra", v_t'(w_rd_o), v_t'(0));
                else begin
                    ew = q_wrd.pop_front();
                    chk("wrd_cyc", v_t'(cyc), v_t'(ew.c));
                    chk("wrd_addr", v_t'(w_addr_o), v_t'(ew.addr));
                end
            end
            if (pix_data_valid_o) begin
                if (q_pix.size() == 0) chk("pix_extra", v_t'(pix_data_valid_o), v_t'(0));
                else begin
                    ep = q_pix.pop_front();
                    chk("pix_cyc", v_t'(cyc), v_t'(ep.c));
                    chk("pix_data", v_t'(pixel_o), v_t'(ep.pix));
                    chk("pix_kval", v_t'(k_val_o), v_t'(ep.kv));
                    chk("pix_kidx", v_t'(kidx_o), v_t'(ep.k));
                end
            end
            if (done_o) begin
                if (q_done.size() == 0) chk("done_extra", v_t'(done_o), v_t'(0));
                else begin
                    ed = q_done.pop_front();
                    chk("done_cyc", v_t'(cyc), v_t'(ed.c));
                    chk("done_err", v_t'(err_o), v_t'(ed.err));
                end
            end
        end
    end

    // Run-level model: per kernel 9 reads, 784 valids, then the engine's finish
    // offset fo (relative to the first drain cycle) decides NEXT or timeout.
    task automatic launch(input int fo [NK], input bit spur, input bit hold);
        int L, D, N;
        logic [KS*KW-1:0] kv;
        start_i  = 1'b1;
        prev_err = run_err;
        run_s    = cyc;
        run_err  = 1'b0;
        L        = cyc + 1;
        for (int k = 0; k < NK; k++) begin
            kv = '0;
            for (int j = KS - 1; j >= 0; j--) kv = (kv << KW) | (KS*KW)'(wmem[k*KS + j]);
            for (int j = 0; j < KS; j++) q_wrd.push_back('{L + j, k*KS + j});
            for (int p = 0; p < NPIX; p++) q_pix.push_back('{L + KS + 1 + p, imem[p], kv, k});
            D = L + KS + NPIX;
            if (spur) fin_at[L + int'($urandom_range(0, KS - 1))] = 1'b1;
            if (fo[k] != NONE) fin_at[D + fo[k]] = 1'b1;
            if (fo[k] >= -NPIX && fo[k] < TO) begin
                N = D + ((fo[k] > 0) ? fo[k] : 0) + 1;
                if (spur) fin_at[N] = 1'b1;
                if (k == NK - 1) run_done = N + 1;
                else L = N + 1;
            end else begin
                run_done = D + TO;
                run_err  = 1'b1;
                break;
            end
        end
        q_done.push_back('{run_done, run_err});
        if (!hold) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
    endtask

    task automatic finish_run();
        while (cyc < run_done + 2) @(negedge clk_i);
        chk("queues_drained", v_t'(q_wrd.size() + q_pix.size() + q_done.size()), v_t'(0));
    endtask

    task automatic chk_reset();
        chk("rst_busy", v_t'(busy_o), v_t'(0));
        chk("rst_done", v_t'(done_o), v_t'(0));
        chk("rst_err", v_t'(err_o), v_t'(0));
        chk("rst_kidx", v_t'(kidx_o), v_t'(0));
        chk("rst_w_rd", v_t'(w_rd_o), v_t'(0));
        chk("rst_w_addr", v_t'(w_addr_o), v_t'(0));
        chk("rst_img_rd", v_t'(img_rd_o), v_t'(0));
        chk("rst_img_addr", v_t'(img_addr_o), v_t'(0));
        chk("rst_k_val", v_t'(k_val_o), v_t'(0));
        chk("rst_pix_valid", v_t'(pix_data_valid_o), v_t'(0));
    endtask

    function automatic int rnd_fo();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 10) return NONE;
        if (r < 45) return int'($urandom_range(0, TO));
        return -int'($urandom_range(1, NPIX));
    endfunction

    int fo_v [NK];

    initial begin
        for (int i = 0; i < 32; i++) wmem[i] = KW'($urandom);
        for (int i = 0; i < 1024; i++) imem[i] = PW'($urandom);
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        fo_v = '{2, 2, 2};
        launch(fo_v, 1'b0, 1'b0);
        finish_run();

        fo_v = '{0, -1, TO - 1};
        launch(fo_v, 1'b1, 1'b0);
        finish_run();

        fo_v = '{-300, NONE, 2};
        launch(fo_v, 1'b1, 1'b0);
        finish_run();

        for (int k = 0; k < NK; k++) fo_v[k] = rnd_fo();
        launch(fo_v, 1'b1, 1'b1);
        while (cyc < run_done + 1) @(negedge clk_i);
        fo_v = '{1, NONE, 0};
        launch(fo_v, 1'b0, 1'b0);
        finish_run();

        fo_v = '{2, 2, 2};
        launch(fo_v, 1'b0, 1'b0);
        while (cyc < run_s + 400) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk_reset();
        q_wrd.delete();
        q_pix.delete();
        q_done.delete();
        fin_at.delete();
        run_s    = -1;
        run_done = -1;
        run_err  = 1'b0;
        prev_err = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        fo_v = '{2, 2, 2};
        launch(fo_v, 1'b0, 1'b0);
        finish_run();

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NK; k++) fo_v[k] = rnd_fo();
            launch(fo_v, 1'($urandom_range(0, 1)), 1'b0);
            finish_run();
            repeat ($urandom_range(1, 5)) @(negedge clk_i);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
